// File: rtl/calculator_seq_pkg.sv
// Shared types, seven-segment constants and sizing helpers for the
// sequential calculator and its BCD converter.
package calculator_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CONV_OP,
        ST_CONV_RES,
        ST_DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Digit 0 occupies the lowest seven bits, digit 9 the highest.
    localparam logic [69:0] SEG_DIGITS = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                          7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        if (digit > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_DIGITS[int'(digit) * 7 +: 7];
    endfunction

    // Accumulator digits: one above the display so overflow is visible, and
    // never fewer than the widest binary value needs, so nothing is lost.
    function automatic int bcd_acc_digits(input int bits, input int d);
        longint maxv = (longint'(1) << bits) - 1;
        int n = 0;
        for (longint v = maxv; v > 0; v = v / 10) begin
            n++;
        end
        if (n < d + 1) begin
            n = d + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/calculator_seq_if.sv
// Request/response bundle between a calculator client and calculator_seq.
interface calculator_seq_if #(
    parameter int W = 7,
    parameter int D = 3
);
    logic           start;
    logic           cal_mode;
    logic           disp_mode;
    logic [W-1:0]   num1;
    logic [W-1:0]   num2;
    logic           busy;
    logic           done;
    logic           neg;
    logic           ovf;
    logic [7*D-1:0] disp_num;
    logic [7*D-1:0] disp_result;

    modport master (
        output start, cal_mode, disp_mode, num1, num2,
        input  busy, done, neg, ovf, disp_num, disp_result
    );

    modport slave (
        input  start, cal_mode, disp_mode, num1, num2,
        output busy, done, neg, ovf, disp_num, disp_result
    );
endinterface

// File: rtl/calculator_seq_bcd_shift_conv.sv
// Iterative binary-to-BCD converter (shift-add-3), MSB first, one bit per
// cycle. Loading consumes the first bit so nbits_i bits take nbits_i cycles.
module bcd_shift_conv #(
    parameter int NB = 8,
    parameter int ND = 4,
    parameter int CW = $clog2(NB + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [NB-1:0]   value_i,
    input  logic [CW-1:0]   nbits_i,
    output logic [4*ND-1:0] bcd_o,
    output logic            ready_o
);
    logic [4*ND-1:0] bcd_q;
    logic [4*ND-1:0] adj_d;
    logic [NB-1:0]   sh_q;
    logic [CW-1:0]   cnt_q;

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_adj
            assign adj_d[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                      bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q <= '0;
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            bcd_q <= {{(4*ND-1){1'b0}}, value_i[NB-1]};
            sh_q  <= {value_i[NB-2:0], 1'b0};
            cnt_q <= nbits_i - 1'b1;
        end else if (cnt_q != '0) begin
            bcd_q <= {adj_d[4*ND-2:0], sh_q[NB-1]};
            sh_q  <= {sh_q[NB-2:0], 1'b0};
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign bcd_o   = bcd_q;
    assign ready_o = (cnt_q == '0);
endmodule

// File: rtl/calculator_seq.sv
// Sequential add/subtract calculator with seven-segment decimal outputs for
// one operand and the result magnitude, sharing a single BCD converter.
module calculator_seq
    import calculator_seq_pkg::*;
#(
    parameter int W   = 7,
    parameter int D   = 3,
    parameter int LZB = 1
) (
    input  logic             clk,
    input  logic             rst,
    calculator_seq_if.slave  bus
);
    localparam int NDIG = bcd_acc_digits(W + 1, D);
    localparam int BW   = 4 * NDIG;
    localparam int CW   = $clog2(W + 2);

    state_t         state_q;
    logic [W-1:0]   num1_q, num2_q;
    logic           cal_q, dsp_q;
    logic [W:0]     mag_q, mag_d;
    logic           neg_pend_q, neg_d;
    logic [BW-1:0]  op_bcd_q, conv_bcd;
    logic           conv_ready, conv_load;
    logic [W:0]     conv_value;
    logic [CW-1:0]  conv_nbits;
    logic           busy_q, done_q, neg_q, ovf_q;
    logic [7*D-1:0] disp_num_q, disp_res_q;
    logic [7*D-1:0] seg_num_d, seg_res_d, seg_rst;
    logic           op_ovf, res_ovf;

    always_comb begin
        neg_d = !cal_q && (num2_q > num1_q);
        if (cal_q) begin
            mag_d = {1'b0, num1_q} + {1'b0, num2_q};
        end else if (neg_d) begin
            mag_d = {1'b0, num2_q} - {1'b0, num1_q};
        end else begin
            mag_d = {1'b0, num1_q} - {1'b0, num2_q};
        end
    end

    // Operand is left-aligned so its W bits finish in W cycles.
    always_comb begin
        conv_load  = 1'b0;
        conv_value = {(dsp_q ? num2_q : num1_q), 1'b0};
        conv_nbits = CW'(W);
        if (state_q == ST_LOAD) begin
            conv_load = 1'b1;
        end else if (state_q == ST_CONV_OP && conv_ready) begin
            conv_load  = 1'b1;
            conv_value = mag_q;
            conv_nbits = CW'(W + 1);
        end
    end

    bcd_shift_conv #(.NB(W + 1), .ND(NDIG), .CW(CW)) u_conv (
        .clk     (clk),
        .rst     (rst),
        .load_i  (conv_load),
        .value_i (conv_value),
        .nbits_i (conv_nbits),
        .bcd_o   (conv_bcd),
        .ready_o (conv_ready)
    );

    assign op_ovf  = |op_bcd_q[BW-1:4*D];
    assign res_ovf = |conv_bcd[BW-1:4*D];

    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_seg
            assign seg_rst[7*gi +: 7] = (gi == 0 || LZB == 0) ? seg_of(4'd0) : SEG_BLANK;
            assign seg_num_d[7*gi +: 7] =
                op_ovf ? SEG_DASH :
                (LZB != 0 && gi != 0 && op_bcd_q[4*D-1:4*gi] == '0) ? SEG_BLANK :
                seg_of(op_bcd_q[4*gi +: 4]);
            assign seg_res_d[7*gi +: 7] =
                res_ovf ? SEG_DASH :
                (LZB != 0 && gi != 0 && conv_bcd[4*D-1:4*gi] == '0) ? SEG_BLANK :
                seg_of(conv_bcd[4*gi +: 4]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            num1_q     <= '0;
            num2_q     <= '0;
            cal_q      <= 1'b0;
            dsp_q      <= 1'b0;
            mag_q      <= '0;
            neg_pend_q <= 1'b0;
            op_bcd_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            disp_num_q <= seg_rst;
            disp_res_q <= seg_rst;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        num1_q  <= bus.num1;
                        num2_q  <= bus.num2;
                        cal_q   <= bus.cal_mode;
                        dsp_q   <= bus.disp_mode;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    mag_q      <= mag_d;
                    neg_pend_q <= neg_d;
                    state_q    <= ST_CONV_OP;
                end
                ST_CONV_OP: begin
                    if (conv_ready) begin
                        op_bcd_q <= conv_bcd;
                        state_q  <= ST_CONV_RES;
                    end
                end
                ST_CONV_RES: begin
                    if (conv_ready) begin
                        disp_num_q <= seg_num_d;
                        disp_res_q <= seg_res_d;
                        neg_q      <= neg_pend_q;
                        ovf_q      <= op_ovf | res_ovf;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.neg         = neg_q;
    assign bus.ovf         = ovf_q;
    assign bus.disp_num    = disp_num_q;
    assign bus.disp_result = disp_res_q;
endmodule

// File: tb/tb_calculator_seq.sv
// Scoreboard bench for calculator_seq: two instances (D=3 blanking, D=2 no
// blanking) share stimulus; a decimal reference model predicts every response.
module tb_calculator_seq;
    localparam int W   = 7;
    localparam int LAT = 2 * W + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    calculator_seq_if #(.W(W), .D(3)) bus_a ();
    calculator_seq_if #(.W(W), .D(2)) bus_b ();

    calculator_seq #(.W(W), .D(3), .LZB(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    calculator_seq #(.W(W), .D(2), .LZB(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        int          acc;
        int          done_edge;
        logic [20:0] num;
        logic [20:0] res;
        logic        neg;
        logic        ovf;
    } exp_t;

    exp_t sbq [2][$];
    exp_t cur [2];
    int   n_vec = 0;
    int   n_bad = 0;
    int   edge_cnt = 0;
    int   free_edge = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int digits_of(input int idx);
        return (idx == 0) ? 3 : 2;
    endfunction

    function automatic int lzb_of(input int idx);
        return (idx == 0) ? 1 : 0;
    endfunction

    function automatic logic [6:0] seg7(input int dgt);
        case (dgt)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  default: return 7'h6F;
        endcase
    endfunction

    function automatic logic [20:0] seg_field(input int v, input int d, input int lzb);
        logic [20:0] f = '0;
        int pw = 1;
        for (int i = 0; i < d; i++) begin
            if (v >= 10 ** d)               f[7*i +: 7] = 7'h40;
            else if (lzb != 0 && i > 0 && v < pw) f[7*i +: 7] = 7'h00;
            else                            f[7*i +: 7] = seg7((v / pw) % 10);
            pw = pw * 10;
        end
        return f;
    endfunction

    function automatic exp_t make_exp(input int e, input int a, input int b,
                                      input bit cm, input bit dm, input int idx);
        exp_t x;
        int mag = cm ? a + b : (b > a ? b - a : a - b);
        int op  = dm ? b : a;
        int lim = 10 ** digits_of(idx);
        x.acc       = e;
        x.done_edge = e + LAT;
        x.num       = seg_field(op, digits_of(idx), lzb_of(idx));
        x.res       = seg_field(mag, digits_of(idx), lzb_of(idx));
        x.neg       = !cm && (b > a);
        x.ovf       = (op >= lim) || (mag >= lim);
        return x;
    endfunction

    task automatic cmp(input string name, input int idx, input logic [20:0] got,
                       input logic [20:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d edge %0d: got %h required %h", name, idx, edge_cnt, got, want);
        end
    endtask

    task automatic check_one(input int idx, input logic g_busy, input logic g_done,
                             input logic g_neg, input logic g_ovf,
                             input logic [20:0] g_num, input logic [20:0] g_res);
        exp_t f;
        bit   have;
        bit   e_busy = 1'b0;
        bit   e_done = 1'b0;
        if (rst) begin
            sbq[idx].delete();
            cur[idx] = make_exp(0, 0, 0, 1'b1, 1'b0, idx);
        end else begin
            have = sbq[idx].size() > 0;
            if (have) begin
                f      = sbq[idx][0];
                e_busy = (edge_cnt >= f.acc) && (edge_cnt <= f.done_edge);
                e_done = (edge_cnt == f.done_edge);
                if (edge_cnt >= f.done_edge) begin
                    cur[idx] = f;
                    void'(sbq[idx].pop_front());
                end
            end
        end
        cmp("busy", idx, 21'(g_busy), 21'(e_busy));
        cmp("done", idx, 21'(g_done), 21'(e_done));
        cmp("neg", idx, 21'(g_neg), 21'(cur[idx].neg));
        cmp("ovf", idx, 21'(g_ovf), 21'(cur[idx].ovf));
        cmp("disp_num", idx, g_num, cur[idx].num);
        cmp("disp_result", idx, g_res, cur[idx].res);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check_one(0, bus_a.busy, bus_a.done, bus_a.neg, bus_a.ovf,
                      21'(bus_a.disp_num), 21'(bus_a.disp_result));
            check_one(1, bus_b.busy, bus_b.done, bus_b.neg, bus_b.ovf,
                      21'(bus_b.disp_num), 21'(bus_b.disp_result));
        end
    end

    // One cycle of stimulus; the model decides whether the DUT accepts start.
    task automatic drive(input bit st, input int a, input int b, input bit cm,
                         input bit dm, input bit r);
        int e;
        @(negedge clk);
        bus_a.start = st;  bus_a.num1 = W'(a);  bus_a.num2 = W'(b);
        bus_a.cal_mode = cm;  bus_a.disp_mode = dm;
        bus_b.start = st;  bus_b.num1 = W'(a);  bus_b.num2 = W'(b);
        bus_b.cal_mode = cm;  bus_b.disp_mode = dm;
        rst = r;
        e = edge_cnt + 1;
        if (r) begin
            free_edge = e + 1;
        end else if (st && e >= free_edge) begin
            sbq[0].push_back(make_exp(e, a, b, cm, dm, 0));
            sbq[1].push_back(make_exp(e, a, b, cm, dm, 1));
            free_edge = e + LAT + 2;
            $display("txn edge %0d: num1=%0d num2=%0d add=%0d show_num2=%0d", e, a, b, cm, dm);
        end
    endtask

    function automatic int rop();
        case ($urandom % 4)
            0:       return 0;
            1:       return (1 << W) - 1;
            default: return int'($urandom_range(0, (1 << W) - 1));
        endcase
    endfunction

    // Issue one calculation, then scramble inputs (with stray starts at
    // offsets 3 and 10) until the model says the DUT is free again.
    task automatic run(input int a, input int b, input bit cm, input bit dm);
        int k = 1;
        drive(1'b1, a, b, cm, dm, 1'b0);
        while (edge_cnt + 1 < free_edge) begin
            drive(k == 3 || k == 10, rop(), rop(), 1'(($urandom)), 1'(($urandom)), 1'b0);
            k++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.num1 = '0; bus_a.num2 = '0;
        bus_a.cal_mode = 1'b0; bus_a.disp_mode = 1'b0;
        bus_b.start = 1'b0; bus_b.num1 = '0; bus_b.num2 = '0;
        bus_b.cal_mode = 1'b0; bus_b.disp_mode = 1'b0;
        repeat (3) drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

        run(100, 27, 1'b1, 1'b0);
        run(5, 9, 1'b0, 1'b0);
        run(60, 50, 1'b1, 1'b0);
        run(127, 127, 1'b1, 1'b0);
        run(0, 0, 1'b0, 1'b0);
        run(0, 127, 1'b0, 1'b1);
        run(99, 0, 1'b1, 1'b1);
        run(100, 0, 1'b0, 1'b0);

        // Abandon a calculation at its eighth cycle, then recover.
        drive(1'b1, 77, 33, 1'b1, 1'b0, 1'b0);
        repeat (7) drive(1'b0, rop(), rop(), 1'b1, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        run(12, 34, 1'b1, 1'b0);

        // start held high: DONE-cycle start ignored, next IDLE cycle accepted.
        repeat (3 * (LAT + 2)) drive(1'b1, rop(), rop(), 1'(($urandom)), 1'(($urandom)), 1'b0);

        repeat (500) drive(($urandom % 5) == 0, rop(), rop(), 1'(($urandom)),
                           1'(($urandom)), ($urandom % 97) == 0);

        repeat (LAT + 4) drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cmp("sb_drain", i, 21'(sbq[i].size()), 21'(0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
